// File: rtl/mips_ctrl_fsm_if.sv
// rtl/mips_ctrl_fsm_if.sv - instruction fields, ALU flags and datapath controls of the multicycle MIPS control unit
interface mips_ctrl_fsm_if #(
   parameter int OPC_W = 6
);
   logic [OPC_W-1:0] opcode;
   logic [OPC_W-1:0] funct;
   logic             zero;
   logic             overflow;
   logic             alu_srca_sel;
   logic [1:0]       alu_srcb_sel;
   logic [2:0]       alu_op;
   logic             aluout_write;
   logic [1:0]       pc_source;
   logic             pc_write;
   logic             iord;
   logic             mem_write;
   logic             ir_write;
   logic             reg_dst;
   logic             mem_to_reg;
   logic             reg_write;
   logic             epc_write;
   logic [4:0]       state;

   modport master (
      input  opcode, funct, zero, overflow,
      output alu_srca_sel, alu_srcb_sel, alu_op, aluout_write, pc_source, pc_write,
             iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, epc_write, state
   );

   modport slave (
      output opcode, funct, zero, overflow,
      input  alu_srca_sel, alu_srcb_sel, alu_op, aluout_write, pc_source, pc_write,
             iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, epc_write, state
   );
endinterface

// File: rtl/mips_ctrl_fsm.sv
// rtl/mips_ctrl_fsm.sv - multicycle MIPS Moore control FSM; CTRL_EXCEPTION_EN enables overflow/illegal traps
module mips_ctrl_fsm #(
   parameter logic [1:0] EXC_VECTOR_SEL = 2'd3,
   parameter int         OPC_W          = 6
) (
   input  logic            clk,
   input  logic            reset,
   mips_ctrl_fsm_if.master bus
);
   localparam logic [4:0] S_RESET      = 5'd0;
   localparam logic [4:0] S_FETCH      = 5'd1;
   localparam logic [4:0] S_FETCH_WAIT = 5'd2;
   localparam logic [4:0] S_IR_LOAD    = 5'd3;
   localparam logic [4:0] S_DECODE     = 5'd4;
   localparam logic [4:0] S_EXEC_R     = 5'd5;
   localparam logic [4:0] S_WB_R       = 5'd6;
   localparam logic [4:0] S_ADDI_EXEC  = 5'd7;
   localparam logic [4:0] S_ADDI_WB    = 5'd8;
   localparam logic [4:0] S_MEM_ADDR   = 5'd9;
   localparam logic [4:0] S_LW_READ    = 5'd10;
   localparam logic [4:0] S_LW_WAIT    = 5'd11;
   localparam logic [4:0] S_LW_WB      = 5'd12;
   localparam logic [4:0] S_SW_WRITE   = 5'd13;
   localparam logic [4:0] S_BRANCH     = 5'd14;
   localparam logic [4:0] S_JUMP       = 5'd15;
   localparam logic [4:0] S_EXC_EPC    = 5'd16;
   localparam logic [4:0] S_EXC_VEC    = 5'd17;

   localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(6'h00);
   localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(6'h08);
   localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(6'h23);
   localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(6'h2B);
   localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(6'h04);
   localparam logic [OPC_W-1:0] OP_BNE   = OPC_W'(6'h05);
   localparam logic [OPC_W-1:0] OP_J     = OPC_W'(6'h02);
   localparam logic [OPC_W-1:0] FN_ADD   = OPC_W'(6'h20);
   localparam logic [OPC_W-1:0] FN_SUB   = OPC_W'(6'h22);
   localparam logic [OPC_W-1:0] FN_AND   = OPC_W'(6'h24);

   localparam logic [2:0] ALU_ADD = 3'b001;
   localparam logic [2:0] ALU_SUB = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;

`ifdef CTRL_EXCEPTION_EN
   localparam bit EXC_EN = 1'b1;
`else
   localparam bit EXC_EN = 1'b0;
`endif

   // Without traps, illegal encodings simply fall back to the next fetch.
   localparam logic [4:0] S_ILLEGAL = EXC_EN ? S_EXC_EPC : S_FETCH;

   logic [4:0] state;
   logic [4:0] nxt;
   logic       r_legal;
   logic       r_arith;
   logic       ovf_trap;

   assign r_arith  = (bus.funct == FN_ADD) || (bus.funct == FN_SUB);
   assign r_legal  = r_arith || (bus.funct == FN_AND);
   assign ovf_trap = EXC_EN & bus.overflow;
   assign bus.state = state;

   always_ff @(posedge clk) begin
      if (reset) state <= S_RESET;
      else       state <= nxt;
   end

   always_comb begin
      nxt = S_FETCH;
      case (state)
         S_RESET:      nxt = S_FETCH;
         S_FETCH:      nxt = S_FETCH_WAIT;
         S_FETCH_WAIT: nxt = S_IR_LOAD;
         S_IR_LOAD:    nxt = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               OP_RTYPE:       nxt = r_legal ? S_EXEC_R : S_ILLEGAL;
               OP_ADDI:        nxt = S_ADDI_EXEC;
               OP_LW, OP_SW:   nxt = S_MEM_ADDR;
               OP_BEQ, OP_BNE: nxt = S_BRANCH;
               OP_J:           nxt = S_JUMP;
               default:        nxt = S_ILLEGAL;
            endcase
         end
         S_EXEC_R:    nxt = (ovf_trap && r_arith) ? S_EXC_EPC : S_WB_R;
         S_ADDI_EXEC: nxt = ovf_trap ? S_EXC_EPC : S_ADDI_WB;
         S_MEM_ADDR:  nxt = (bus.opcode == OP_LW) ? S_LW_READ : S_SW_WRITE;
         S_LW_READ:   nxt = S_LW_WAIT;
         S_LW_WAIT:   nxt = S_LW_WB;
         S_EXC_EPC:   nxt = S_EXC_VEC;
         default:     nxt = S_FETCH;
      endcase
   end

   always_comb begin
      bus.alu_srca_sel = 1'b0;
      bus.alu_srcb_sel = 2'd0;
      bus.alu_op       = 3'b000;
      bus.aluout_write = 1'b0;
      bus.pc_source    = 2'd0;
      bus.pc_write     = 1'b0;
      bus.iord         = 1'b0;
      bus.mem_write    = 1'b0;
      bus.ir_write     = 1'b0;
      bus.reg_dst      = 1'b0;
      bus.mem_to_reg   = 1'b0;
      bus.reg_write    = 1'b0;
      bus.epc_write    = 1'b0;
      case (state)
         S_FETCH: begin
            bus.alu_srcb_sel = 2'd1;
            bus.alu_op       = ALU_ADD;
            bus.pc_write     = 1'b1;
         end
         S_IR_LOAD: bus.ir_write = 1'b1;
         S_DECODE: begin
            bus.alu_srcb_sel = 2'd3;
            bus.alu_op       = ALU_ADD;
            bus.aluout_write = 1'b1;
         end
         S_EXEC_R: begin
            bus.alu_srca_sel = 1'b1;
            bus.aluout_write = 1'b1;
            case (bus.funct)
               FN_ADD:  bus.alu_op = ALU_ADD;
               FN_SUB:  bus.alu_op = ALU_SUB;
               FN_AND:  bus.alu_op = ALU_AND;
               default: bus.alu_op = 3'b000;
            endcase
         end
         S_WB_R: begin
            bus.reg_dst   = 1'b1;
            bus.reg_write = 1'b1;
         end
         S_ADDI_EXEC, S_MEM_ADDR: begin
            bus.alu_srca_sel = 1'b1;
            bus.alu_srcb_sel = 2'd2;
            bus.alu_op       = ALU_ADD;
            bus.aluout_write = 1'b1;
         end
         S_ADDI_WB: bus.reg_write = 1'b1;
         S_LW_READ, S_LW_WAIT: bus.iord = 1'b1;
         S_LW_WB: begin
            bus.mem_to_reg = 1'b1;
            bus.reg_write  = 1'b1;
         end
         S_SW_WRITE: begin
            bus.iord      = 1'b1;
            bus.mem_write = 1'b1;
         end
         S_BRANCH: begin
            // Only Mealy-style output: the branch decision follows the live zero flag.
            bus.alu_srca_sel = 1'b1;
            bus.alu_op       = ALU_SUB;
            bus.pc_source    = 2'd1;
            bus.pc_write     = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
         end
         S_JUMP: begin
            bus.pc_source = 2'd2;
            bus.pc_write  = 1'b1;
         end
         S_EXC_EPC: begin
            bus.alu_srcb_sel = 2'd1;
            bus.alu_op       = ALU_SUB;
            bus.epc_write    = EXC_EN;
         end
         S_EXC_VEC: begin
            bus.pc_source = EXC_VECTOR_SEL;
            bus.pc_write  = 1'b1;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// tb/tb_mips_ctrl_fsm.sv - self-checking bench for mips_ctrl_fsm against an instruction-level cycle model
module tb_mips_ctrl_fsm;
   typedef struct packed {
      logic       srca;
      logic [1:0] srcb;
      logic [2:0] op;
      logic       aluw;
      logic [1:0] pcs;
      logic       pcw;
      logic       iord;
      logic       memw;
      logic       irw;
      logic       regdst;
      logic       m2r;
      logic       regw;
      logic       epcw;
   } ctl_t;

`ifdef CTRL_EXCEPTION_EN
   localparam bit EXC = 1'b1;
`else
   localparam bit EXC = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   ctl_t exp_q[$];
   ctl_t obs_q[$];

   mips_ctrl_fsm_if #(.OPC_W(6)) bus ();

   mips_ctrl_fsm dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic ctl_t sample();
      ctl_t c;
      c = {bus.alu_srca_sel, bus.alu_srcb_sel, bus.alu_op, bus.aluout_write, bus.pc_source,
           bus.pc_write, bus.iord, bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg,
           bus.reg_write, bus.epc_write};
      return c;
   endfunction

   task automatic push_exc();
      ctl_t c;
      c = '0; c.srcb = 2'd1; c.op = 3'b010; c.epcw = 1'b1; exp_q.push_back(c);
      c = '0; c.pcs = 2'd3; c.pcw = 1'b1; exp_q.push_back(c);
   endtask

   // Expected control word for every cycle of one instruction, FETCH to last state.
   task automatic build_exp(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic ov);
      ctl_t c;
      bit   legal_r;
      legal_r = (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24);
      exp_q.delete();
      c = '0; c.srcb = 2'd1; c.op = 3'b001; c.pcw = 1'b1; exp_q.push_back(c);
      c = '0; exp_q.push_back(c);
      c = '0; c.irw = 1'b1; exp_q.push_back(c);
      c = '0; c.srcb = 2'd3; c.op = 3'b001; c.aluw = 1'b1; exp_q.push_back(c);
      if (op == 6'h00 && legal_r) begin
         c = '0; c.srca = 1'b1; c.aluw = 1'b1;
         c.op = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
         exp_q.push_back(c);
         if (EXC && ov && fn != 6'h24) push_exc();
         else begin c = '0; c.regdst = 1'b1; c.regw = 1'b1; exp_q.push_back(c); end
      end else if (op == 6'h08) begin
         c = '0; c.srca = 1'b1; c.srcb = 2'd2; c.op = 3'b001; c.aluw = 1'b1; exp_q.push_back(c);
         if (EXC && ov) push_exc();
         else begin c = '0; c.regw = 1'b1; exp_q.push_back(c); end
      end else if (op == 6'h23 || op == 6'h2B) begin
         c = '0; c.srca = 1'b1; c.srcb = 2'd2; c.op = 3'b001; c.aluw = 1'b1; exp_q.push_back(c);
         if (op == 6'h23) begin
            c = '0; c.iord = 1'b1; exp_q.push_back(c); exp_q.push_back(c);
            c = '0; c.m2r = 1'b1; c.regw = 1'b1; exp_q.push_back(c);
         end else begin
            c = '0; c.iord = 1'b1; c.memw = 1'b1; exp_q.push_back(c);
         end
      end else if (op == 6'h04 || op == 6'h05) begin
         c = '0; c.srca = 1'b1; c.op = 3'b010; c.pcs = 2'd1;
         c.pcw = (op == 6'h04) ? z : ~z;
         exp_q.push_back(c);
      end else if (op == 6'h02) begin
         c = '0; c.pcs = 2'd2; c.pcw = 1'b1; exp_q.push_back(c);
      end else if (EXC) begin
         push_exc();
      end
   endtask

   // Called #1 after the edge that enters FETCH; returns #1 after the edge that leaves the last state.
   task automatic capture(input int n);
      obs_q.delete();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         obs_q.push_back(sample());
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic ov);
      bus.opcode = op; bus.funct = fn; bus.zero = z; bus.overflow = ov;
      build_exp(op, fn, z, ov);
      capture(exp_q.size());
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.state !== 5'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", bus.state); end
      checks++;
      if (sample() !== ctl_t'(0)) begin errors++; $display("FAIL reset_outputs got %h exp 0", sample()); end
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_rtype();
      logic [5:0] fns [3];
      fns = '{6'h22, 6'h20, 6'h24};
      for (int k = 0; k < 3; k++) begin
         run(6'h00, fns[k], 1'($urandom), 1'b0);
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++; $display("FAIL rtype fn=%h cyc%0d got %h exp %h", fns[k], i, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_load_store();
      run(6'h23, 6'($urandom), 1'($urandom), 1'($urandom));
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL lw cyc%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
      end
      run(6'h2B, 6'($urandom), 1'($urandom), 1'($urandom));
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL sw cyc%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_branch_jump();
      logic [5:0] ops [5];
      logic       zs  [5];
      ops = '{6'h04, 6'h05, 6'h04, 6'h05, 6'h02};
      zs  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 5; k++) begin
         run(ops[k], 6'($urandom), zs[k], 1'b0);
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++; $display("FAIL branch op=%h z=%b cyc%0d got %h exp %h", ops[k], zs[k], i, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_exceptions();
      logic [5:0] ops [5];
      logic [5:0] fns [5];
      ops = '{6'h08, 6'h3F, 6'h00, 6'h00, 6'h00};
      fns = '{6'h00, 6'h20, 6'h25, 6'h22, 6'h24};
      for (int k = 0; k < 5; k++) begin
         run(ops[k], fns[k], 1'b0, 1'b1);
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++; $display("FAIL exc op=%h fn=%h cyc%0d got %h exp %h", ops[k], fns[k], i, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_lw();
      bus.opcode = 6'h23; bus.funct = 6'h00; bus.zero = 1'b0; bus.overflow = 1'b0;
      build_exp(6'h23, 6'h00, 1'b0, 1'b0);
      capture(6);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL lw_pre cyc%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
      end
      @(negedge clk);
      checks++;
      if (bus.iord !== 1'b1) begin errors++; $display("FAIL lw_wait_iord got %b exp 1", bus.iord); end
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (bus.state !== 5'd0) begin errors++; $display("FAIL midrst_state k%0d got %0d exp 0", k, bus.state); end
         checks++;
         if (sample() !== ctl_t'(0)) begin errors++; $display("FAIL midrst_outputs k%0d got %h exp 0", k, sample()); end
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      logic [5:0] op;
      logic [5:0] fn;
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 9))
            0, 1:    op = 6'h00;
            2:       op = 6'h08;
            3:       op = 6'h23;
            4:       op = 6'h2B;
            5:       op = 6'h04;
            6:       op = 6'h05;
            7:       op = 6'h02;
            8:       op = 6'h3F;
            default: op = 6'($urandom);
         endcase
         case ($urandom_range(0, 3))
            0:       fn = 6'h20;
            1:       fn = 6'h22;
            2:       fn = 6'h24;
            default: fn = 6'($urandom);
         endcase
         run(op, fn, 1'($urandom), 1'($urandom));
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++; $display("FAIL b2b n%0d op=%h fn=%h cyc%0d got %h exp %h", n, op, fn, i, obs_q[i], exp_q[i]);
            end
            checks++;
            if ($countones({obs_q[i].regw, obs_q[i].memw, obs_q[i].irw}) > 1) begin
               errors++; $display("FAIL write_mutex n%0d cyc%0d got %h exp at most one", n, i, obs_q[i]);
            end
         end
      end
   endtask

   initial begin
      bus.opcode = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.overflow = 1'b0;
      test_reset();
      test_rtype();
      test_load_store();
      test_branch_jump();
      test_exceptions();
      test_reset_mid_lw();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
